// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared access-size codes, lane constants and FSM states for the MEM-stage LSU
package lsu_pkg;

  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte-enable generation, store lane replication and load extraction/extension
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  ls_i,
  input  logic        ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  // Lane selection; code 11 and unknown sizes fall back to a full word
  always_comb begin
    half_v  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    byte_v  = rdata_i[{addr_lo_i, 3'b000} +: 8];
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (ls_i)
      LS_HALF: begin
        be_o    = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{ext_i & half_v[15]}}, half_v};
      end
      LS_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{ext_i & byte_v[7]}}, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// rtl/mem_lsu_ctrl.sv - MEM-stage load/store FSM on a handshaked data-memory port (option: LSU_MISALIGN_TRAP_EN)
module mem_lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [31:0]       EX_MEM_alu_out,
  input  logic [31:0]       EX_MEM_regfile_out2,
  input  logic [1:0]        LS_bit,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              Ext_op,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_err,
  output logic              lsu_misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [1:0]        ls_q, ls_d;
  logic              ext_q, ext_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;

  logic              req_any, in_idle, misalign, timeout;
  logic [1:0]        lane_lo, lane_ls;
  logic              lane_ext;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata, lane_rdata;
  logic              unused_addr;

  assign req_any     = MemRead | MemWrite;
  assign in_idle     = (state_q == S_IDLE);
  assign timeout     = (cnt_q == TO_LAST);
  assign unused_addr = ^EX_MEM_alu_out[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (LS_bit == LS_HALF) ? EX_MEM_alu_out[0] :
                    (LS_bit == LS_BYTE) ? 1'b0 : (EX_MEM_alu_out[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Request lanes come straight from the pipeline in IDLE; response lanes from the latched copy
  assign lane_lo  = in_idle ? EX_MEM_alu_out[1:0] : addr_lo_q;
  assign lane_ls  = in_idle ? LS_bit : ls_q;
  assign lane_ext = in_idle ? Ext_op : ext_q;

  lsu_lane u_lane (
    .addr_lo_i (lane_lo),
    .ls_i      (lane_ls),
    .ext_i     (lane_ext),
    .wdata_i   (EX_MEM_regfile_out2),
    .rdata_i   (mem_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

  // Next-state and registered-output logic; err/misalign flags live only for the DONE cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_lo_d   = addr_lo_q;
    ls_d        = ls_q;
    ext_d       = ext_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    mis_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          addr_lo_d = EX_MEM_alu_out[1:0];
          ls_d      = LS_bit;
          ext_d     = Ext_op;
          cnt_d     = 8'd0;
          if (misalign) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite;
            mem_addr_d  = EX_MEM_alu_out[ADDR_W+1:2];
            mem_be_d    = lane_be;
            mem_wdata_d = lane_wdata;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          rdata_d   = 32'd0;
        end else if (mem_gnt) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          state_d = S_DONE;
          if (!mem_we_q) rdata_d = lane_rdata;
        end else if (timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously so a hung access is dropped at once
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      addr_lo_q   <= 2'd0;
      ls_q        <= LS_WORD;
      ext_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      ls_q        <= ls_d;
      ext_q       <= ext_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
    end
  end

  assign lsu_stall    = (in_idle & req_any) | (state_q == S_REQ) | (state_q == S_WAIT);
  assign lsu_done     = (state_q == S_DONE);
  assign lsu_rdata    = rdata_q;
  assign lsu_err      = err_q;
  assign lsu_misalign = mis_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// tb/tb_mem_lsu_ctrl.sv - directed self-checking bench for mem_lsu_ctrl (option: LSU_MISALIGN_TRAP_EN)
module tb_mem_lsu_ctrl;
  import lsu_pkg::*;

  localparam int ADDR_W      = 10;
  localparam int TIMEOUT_CYC = 255;

  logic              clock, rst_n;
  logic [31:0]       EX_MEM_alu_out, EX_MEM_regfile_out2, mem_rdata, lsu_rdata, mem_wdata;
  logic [1:0]        LS_bit;
  logic              MemWrite, MemRead, Ext_op, mem_gnt, mem_rvalid;
  logic              lsu_stall, lsu_done, lsu_err, lsu_misalign, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;

  mem_lsu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clock(clock), .rst_n(rst_n),
    .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_regfile_out2(EX_MEM_regfile_out2),
    .LS_bit(LS_bit), .MemWrite(MemWrite), .MemRead(MemRead), .Ext_op(Ext_op),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err), .lsu_misalign(lsu_misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Expected transaction, computed from the access rules when it is issued
  bit                active = 1'b0;
  int                e_t0, e_gd, e_done_rel;
  logic              e_mis, e_err, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [3:0]        e_be;
  logic [31:0]       e_wdata, e_rdata;
  logic [31:0]       last_rd = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int sz(input logic [1:0] ls);
    case (ls)
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 4;
    endcase
  endfunction

  // Per-cycle comparison against the expected transaction timeline
  always @(negedge clock) begin : cmp
    int rel;
    bit x_stall, x_done, x_req;
    if (!rst_n) begin
      chk("rst_stall", 32'(lsu_stall), 32'd0);
      chk("rst_done", 32'(lsu_done), 32'd0);
      chk("rst_rdata", lsu_rdata, 32'd0);
      chk("rst_err", 32'(lsu_err), 32'd0);
      chk("rst_mis", 32'(lsu_misalign), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_be", 32'(mem_be), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
    end else if (!active) begin
      chk("idle_stall", 32'(lsu_stall), 32'd0);
      chk("idle_done", 32'(lsu_done), 32'd0);
      chk("idle_req", 32'(mem_req), 32'd0);
    end else begin
      rel     = cyc - e_t0;
      x_stall = rel < e_done_rel;
      x_done  = rel == e_done_rel;
      x_req   = !e_mis && rel >= 1 && rel <= 1 + e_gd && rel < e_done_rel;
      chk("stall", 32'(lsu_stall), 32'(x_stall));
      chk("done", 32'(lsu_done), 32'(x_done));
      chk("req", 32'(mem_req), 32'(x_req));
      if (x_req) begin
        chk("addr", 32'(mem_addr), 32'(e_addr));
        chk("be", 32'(mem_be), 32'(e_be));
        chk("we", 32'(mem_we), 32'(e_we));
        if (e_we) chk("wdata", mem_wdata, e_wdata);
      end
      if (x_done) begin
        chk("rdata", lsu_rdata, e_rdata);
        chk("err", 32'(lsu_err), 32'(e_err));
        chk("misalign", 32'(lsu_misalign), 32'(e_mis));
      end
    end
  end

  // One pipeline access: request held while stalled and through DONE; memory answers on a fixed schedule
  task automatic xact(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] ls, input logic ext, input logic [31:0] rdat,
                      input int gd, input int rdl, input int abort_rel,
                      input logic lit_en, input logic [ADDR_W-1:0] l_addr, input logic [3:0] l_be,
                      input logic [31:0] l_wdata, input logic [31:0] l_rdata, input int l_stall);
    int s, off, full, stall_cnt, done_cnt;
    logic [31:0] mask, rv;
    s   = sz(ls);
    off = int'(a[1:0]) & ~(s - 1);
    e_be = 4'(((1 << s) - 1) << off);
    for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = d[8*(i % s) +: 8];
    mask = (s == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * s)) - 1);
    rv   = (rdat >> (8 * off)) & mask;
    if (ext && s < 4 && rv[8*s-1]) rv = rv | ~mask;
`ifdef LSU_MISALIGN_TRAP_EN
    e_mis = (s == 4 && a[1:0] != 2'b00) || (s == 2 && a[0]);
`else
    e_mis = 1'b0;
`endif
    full       = gd + rdl + 3;
    e_err      = !e_mis && full > TIMEOUT_CYC + 1;
    e_done_rel = e_mis ? 1 : (e_err ? TIMEOUT_CYC + 1 : full);
    e_rdata    = (e_mis || e_err) ? 32'd0 : ((!w && r) ? rv : last_rd);
    e_addr     = a[ADDR_W+1:2];
    e_we       = w;
    e_gd       = gd;
    e_t0       = cyc;
    active     = 1'b1;
    stall_cnt  = 0;
    done_cnt   = 0;
    for (int rel = 0; rel <= e_done_rel; rel++) begin
      MemWrite = w; MemRead = r; EX_MEM_alu_out = a; EX_MEM_regfile_out2 = d;
      LS_bit = ls; Ext_op = ext; mem_rdata = rdat;
      mem_gnt    = (rel == 1 + gd);
      mem_rvalid = (rel == 2 + gd + rdl);
      if (rel == abort_rel) begin
        active = 1'b0;
        #2;
        MemWrite = 1'b0; MemRead = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_stall", 32'(lsu_stall), 32'd0);
        chk("async_rst_be", 32'(mem_be), 32'd0);
        chk("async_rst_addr", 32'(mem_addr), 32'd0);
        @(posedge clock); #1;
        rst_n = 1'b1;
        last_rd = 32'd0;
        return;
      end
      #1;
      stall_cnt += int'(lsu_stall);
      done_cnt  += int'(lsu_done);
      if (lit_en && rel == 1) begin
        chk("lit_addr", 32'(mem_addr), 32'(l_addr));
        chk("lit_be", 32'(mem_be), 32'(l_be));
        if (w) chk("lit_wdata", mem_wdata, l_wdata);
      end
      if (lit_en && rel == e_done_rel) chk("lit_rdata", lsu_rdata, l_rdata);
      @(posedge clock); #1;
    end
    MemWrite = 1'b0; MemRead = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    active  = 1'b0;
    last_rd = e_rdata;
    chk("done_pulses", 32'(done_cnt), 32'd1);
    if (l_stall >= 0) chk("stall_cycles", 32'(stall_cnt), 32'(l_stall));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; Ext_op = 1'b0; LS_bit = LS_WORD;
    EX_MEM_alu_out = 32'd0; EX_MEM_regfile_out2 = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    @(posedge clock); #1;
    //   w  r  addr          data          ls       ext   rdata         gd rd   abort lit  l_addr l_be   l_wdata       l_rdata       l_stall
    xact(1, 0, 32'h0000_0008, 32'hDEAD_BEEF, LS_WORD, 1'b0, 32'h0,        0, 0,   -1,  1, 10'd2, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 3);
    xact(0, 1, 32'h0000_0006, 32'h0,        LS_HALF, 1'b1, 32'h8001_7FFF, 0, 0,   -1,  1, 10'd1, 4'hC, 32'h0,        32'hFFFF_8001, 3);
    xact(0, 1, 32'h0000_0006, 32'h0,        LS_HALF, 1'b0, 32'h8001_7FFF, 0, 0,   -1,  1, 10'd1, 4'hC, 32'h0,        32'h0000_8001, 3);
    xact(1, 0, 32'h0000_0003, 32'h0000_00A5, LS_BYTE, 1'b0, 32'h0,        0, 0,   -1,  1, 10'd0, 4'h8, 32'hA5A5_A5A5, 32'h0000_8001, 3);
    xact(0, 1, 32'h0000_0003, 32'h0,        LS_BYTE, 1'b1, 32'hA500_0000, 0, 0,   -1,  1, 10'd0, 4'h8, 32'h0,        32'hFFFF_FFA5, 3);
    xact(0, 1, 32'h0000_0010, 32'h0,        LS_WORD, 1'b0, 32'h1234_5678, 4, 5,   -1,  1, 10'd4, 4'hF, 32'h0,        32'h1234_5678, 12);
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    repeat (3) @(posedge clock);
    #1 mem_gnt = 1'b0; mem_rvalid = 1'b0;
    xact(0, 1, 32'h0000_0001, 32'h0,        LS_BYTE, 1'b0, 32'h0000_FF00, 0, 0,   -1,  1, 10'd0, 4'h2, 32'h0,        32'h0000_00FF, 3);
    xact(0, 1, 32'h0000_0020, 32'h0,        LS_WORD, 1'b0, 32'hFFFF_FFFF, 0, 1000, -1, 1, 10'd8, 4'hF, 32'h0,        32'h0000_0000, 256);
    xact(0, 1, 32'h0000_0005, 32'h0,        LS_WORD, 1'b0, 32'h1122_3344, 0, 0,   -1,  0, 10'd0, 4'h0, 32'h0,        32'h0,         -1);
    xact(0, 1, 32'h0000_0040, 32'h0,        LS_WORD, 1'b0, 32'h0,        0, 1000, 4,  0, 10'd0, 4'h0, 32'h0,        32'h0,         -1);
    @(posedge clock); #1;
    xact(1, 1, 32'h0000_0002, 32'h1234_BEEF, LS_HALF, 1'b0, 32'h0,        0, 0,   -1,  1, 10'd0, 4'hC, 32'hBEEF_BEEF, 32'h0000_0000, 3);
    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
